// File: rtl/multi_debouncer_pkg.sv
// Shared defaults and width helper for the multi-channel debouncer.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package multi_debouncer_pkg;

  localparam int DEF_N_CH         = 4;
  localparam int DEF_TICK_DIV     = 5000;
  localparam int DEF_STABLE_TICKS = 4;
  localparam int DEF_LONG_TICKS   = 200;

  // Bits needed to hold every value 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/multi_debouncer_tick_gen.sv
// Shared sample-tick prescaler: counts 0..TICK_DIV-1 and wraps.
// Latency: tick is high for the one cycle the count sits at TICK_DIV-1.
// Backpressure: none, free-running.
module tick_gen
  import multi_debouncer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               CNT_W = cnt_width(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Wrapping prescaler; reset restarts the phase so the first tick lands TICK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer with press/release/long-press strobes.
// Latency: raw change to btn_state within 2 + TICK_DIV*STABLE_TICKS + 1 cycles.
// Backpressure: none, strobes are single-cycle and unqualified.
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press
);

  localparam int STAB_W = cnt_width(STABLE_TICKS);
  localparam int HOLD_W = cnt_width(LONG_TICKS);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

  logic [N_CH-1:0] sync_meta;
  logic [N_CH-1:0] sync;
  logic            tick;

  // Two-flop synchroniser; only its second stage feeds the channel logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [STAB_W-1:0] stab_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              state_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              differ;
    logic              accept;

    assign differ = sync[i] ^ state_q;
    // This tick is the STABLE_TICKS-th consecutive differing sample.
    assign accept = tick & differ & (stab_cnt == STAB_LAST);

    // Debounce counter, accepted level, hold counter and the three strobes.
    always_ff @(posedge clk) begin
      if (rst) begin
        stab_cnt  <= '0;
        hold_cnt  <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        if (tick) begin
          if (!differ) begin
            stab_cnt <= '0;
          end else if (accept) begin
            stab_cnt  <= '0;
            state_q   <= ~state_q;
            press_q   <= ~state_q;
            release_q <= state_q;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end

          // A release on this tick wins over hold growth, so no late long press.
          if (!state_q || accept) begin
            hold_cnt <= '0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
            long_q   <= (hold_cnt == HOLD_LAST);
          end
        end
      end
    end

    assign btn_state[i]     = state_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign long_press[i]    = long_q;
  end

endmodule
